// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector, flush pulse with restart PC, and a consecutive-stall watchdog.
// Define PIPE_CTRL_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_ctrl #(
    parameter int unsigned STALL_LIMIT = 1024,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned RUN_W = $clog2(STALL_LIMIT + 1);

    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       stall_vec;
    logic             stall_any;
    logic [RUN_W-1:0] run_cnt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stall vector; requests are ignored for the vector while flushing
    always_comb begin
        state_nxt = state;
        stall_vec = STALL_NONE;
        if (state != FLUSH) begin
            if (stallreq_ex) begin
                stall_vec = STALL_EX;
            end else if (stallreq_id) begin
                stall_vec = STALL_ID;
            end
        end
        if (flush_req) begin
            state_nxt = FLUSH;
        end else if (stallreq_id || stallreq_ex) begin
            state_nxt = STALL;
        end else begin
            state_nxt = RUN;
        end
    end

    // Stall is combinational, so reset gates it to keep all outputs clear during reset
    assign stall     = rst ? stall_vec : STALL_NONE;
    assign stall_any = |stall_vec;
    assign flush     = (state == FLUSH);

    // Restart PC captured whenever a flush is requested
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            new_pc <= 32'h0;
        end else if (flush_req) begin
            new_pc <= flush_pc;
        end
    end

    // Consecutive-stall watchdog; timeout is sticky until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt       <= '0;
            stall_timeout <= 1'b0;
        end else if (stall_any) begin
            if (run_cnt < RUN_W'(STALL_LIMIT)) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
            if (run_cnt >= RUN_W'(STALL_LIMIT - 1)) begin
                stall_timeout <= 1'b1;
            end
        end else begin
            run_cnt <= '0;
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Free-running event counters, wrapping at 2^CNT_W
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_any) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (state == FLUSH) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed table, multi-cycle corner sequences, randomized run vs. model.
module tb_pipe_ctrl;

    localparam int unsigned LIMIT = 8;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: flush-pending flag, captured PC, length of current stall run, counters
    bit          m_flush;
    logic [31:0] m_pc;
    int          m_run;
    bit          m_to;
    logic [31:0] m_scnt;
    logic [31:0] m_fcnt;

    pipe_ctrl #(.STALL_LIMIT(LIMIT), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_timeout(stall_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic        ex;
        logic        fr;
        logic [31:0] pc;
        logic [5:0]  s;
        logic        f;
        logic [31:0] npc;
        logic [31:0] sc;
        logic [31:0] fc;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef PIPE_CTRL_PERF_CNT_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    function automatic logic [5:0] model_stall(input bit in_flush, input logic id, input logic ex);
        if (in_flush) return 6'd0;
        if (ex)       return 6'b001111;
        if (id)       return 6'b000111;
        return 6'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flush = 0;
        m_pc    = 32'h0;
        m_run   = 0;
        m_to    = 0;
        m_scnt  = 32'h0;
        m_fcnt  = 32'h0;
    endtask

    task automatic model_edge();
        logic [5:0] s;
        s = model_stall(m_flush, stallreq_id, stallreq_ex);
        if (s != 6'd0) begin
            m_run++;
            m_scnt = m_scnt + 32'd1;
        end else begin
            m_run = 0;
        end
        if (m_run >= int'(LIMIT)) m_to = 1;
        if (m_flush) m_fcnt = m_fcnt + 32'd1;
        if (flush_req) m_pc = flush_pc;
        m_flush = flush_req;
    endtask

    task automatic drive(input logic id, input logic ex, input logic fr, input logic [31:0] pc);
        stallreq_id = id;
        stallreq_ex = ex;
        flush_req   = fr;
        flush_pc    = pc;
        #2;
    endtask

    task automatic edge_adv();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".stall"},   32'(stall),         32'(model_stall(m_flush, stallreq_id, stallreq_ex)));
        check({tag, ".flush"},   32'(flush),         32'(m_flush));
        check({tag, ".new_pc"},  new_pc,             m_pc);
        check({tag, ".timeout"}, 32'(stall_timeout), 32'(m_to));
        check({tag, ".scnt"},    stall_cnt,          cnt_exp(m_scnt));
        check({tag, ".fcnt"},    flush_cnt,          cnt_exp(m_fcnt));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        6'b000111, 1'b0, 32'h0,        32'd0, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        6'b000111, 1'b0, 32'h0,        32'd1, 32'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        6'b000111, 1'b0, 32'h0,        32'd2, 32'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        6'b001111, 1'b0, 32'h0,        32'd3, 32'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        6'b001111, 1'b0, 32'h0,        32'd4, 32'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0,        32'd5, 32'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'hBFC00380, 6'b001111, 1'b0, 32'h0,        32'd5, 32'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        6'b000000, 1'b1, 32'hBFC00380, 32'd6, 32'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'hBFC00380, 32'd6, 32'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h100,      6'b000000, 1'b0, 32'hBFC00380, 32'd6, 32'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h200,      6'b000000, 1'b1, 32'h100,      32'd6, 32'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b1, 32'h200,      32'd6, 32'd2};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h200,      32'd6, 32'd3};

        // Reset with requests active: every output must stay clear
        rst = 1'b0;
        model_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        check("reset.stall",   32'(stall),         32'h0);
        check("reset.flush",   32'(flush),         32'h0);
        check("reset.new_pc",  new_pc,             32'h0);
        check("reset.timeout", 32'(stall_timeout), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            check_model("idle");
            check("idle.stall_zero", 32'(stall), 32'h0);
            edge_adv();
        end

        // Directed table: stall priority, flush latency, back-to-back flush
        for (int r = 0; r < 13; r++) begin
            drive(tbl[r].id, tbl[r].ex, tbl[r].fr, tbl[r].pc);
            check($sformatf("tbl%0d.stall", r),  32'(stall), 32'(tbl[r].s));
            check($sformatf("tbl%0d.flush", r),  32'(flush), 32'(tbl[r].f));
            check($sformatf("tbl%0d.new_pc", r), new_pc,     tbl[r].npc);
            check($sformatf("tbl%0d.scnt", r),   stall_cnt,  cnt_exp(tbl[r].sc));
            check($sformatf("tbl%0d.fcnt", r),   flush_cnt,  cnt_exp(tbl[r].fc));
            check($sformatf("tbl%0d.timeout", r), 32'(stall_timeout), 32'h0);
            edge_adv();
        end

        // Watchdog: timeout appears after the LIMIT-th stalled edge and is sticky
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            check($sformatf("wd%0d.timeout", k), 32'(stall_timeout), 32'(k >= int'(LIMIT)));
            check_model("wd");
            edge_adv();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            check("wd.sticky", 32'(stall_timeout), 32'h1);
            edge_adv();
        end

        // Asynchronous reset in the middle of a FLUSH cycle
        drive(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        edge_adv();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("arst.pre_flush",  32'(flush), 32'h1);
        check("arst.pre_new_pc", new_pc,     32'hDEADBEEF);
        check("arst.pre_timeout", 32'(stall_timeout), 32'h1);
        rst = 1'b0;
        #1;
        check("arst.flush",   32'(flush),         32'h0);
        check("arst.stall",   32'(stall),         32'h0);
        check("arst.new_pc",  new_pc,             32'h0);
        check("arst.timeout", 32'(stall_timeout), 32'h0);
        check("arst.scnt",    stall_cnt,          32'h0);
        check("arst.fcnt",    flush_cnt,          32'h0);
        model_reset();
        stallreq_ex = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Randomized traffic with periodic long stall bursts
        for (int i = 0; i < 400; i++) begin
            logic id, ex, fr;
            id = 1'($urandom_range(0, 1));
            ex = ((i % 100) < 12) || ($urandom_range(0, 2) == 0);
            fr = ((i % 100) >= 12) && ($urandom_range(0, 7) == 0);
            drive(id, ex, fr, $urandom);
            check_model("rand");
            edge_adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit. Collects stall requests from decode and execute, plus flush requests from the exception logic.
- Drives the 6-bit stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Also drives the pipeline flush pulse and the restart PC.
- Contains a consecutive-stall watchdog and optional performance counters.

Parameters:
- STALL_LIMIT, 1024: number of consecutive stalled cycles after which the timeout flag sets.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- stallreq_id  in  1  decode stage requests a stall (load-use hazard).
- stallreq_ex  in  1  execute stage requests a stall (multi-cycle operation).
- flush_req  in  1  exception/eret detected; one-cycle pulse.
- flush_pc  in  32  handler/return address; valid when flush_req=1.
- stall  out  6  stall vector; 1 = Stop. Bits: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
- flush  out  1  flush all pipeline registers this cycle.
- new_pc  out  32  restart PC; meaningful only when flush=1.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cnt  out  CNT_W  total stalled cycles.
- flush_cnt  out  CNT_W  total flushes.

Behaviour:
Reset (rst=0, asynchronous):
- state=RUN.
- stall=6'b000000, flush=0, new_pc=32'h0, stall_timeout=0.
- Run counter=0, stall_cnt=0, flush_cnt=0.

States: RUN, STALL, FLUSH.

Stall vector is combinational from requests and state, valid in the same cycle:
- In RUN or STALL:
  - stallreq_ex=1 -> stall=6'b001111.
  - else stallreq_id=1 -> stall=6'b000111.
  - else 6'b000000.
  - stallreq_ex has priority when both are asserted.
- In FLUSH: stall=6'b000000 and both requests are ignored.

Flush:
- flush_req=1 in any state: flush_pc is latched into new_pc and state goes to FLUSH on the next edge.
- In FLUSH: flush=1 for exactly that cycle.
- Next state from FLUSH:
  - flush_req=1 again -> stay in FLUSH, re-latch new_pc, and flush stays 1 another cycle.
  - else -> RUN if no stall request, STALL if any stall request.
- Latency: flush asserts 1 cycle after flush_req.
- flush_req together with a stall request in the same cycle: the stall vector applies that cycle; the flush follows on the next.
- new_pc holds its value outside FLUSH.

State transitions outside FLUSH:
- RUN -> STALL when any request is seen at the edge.
- STALL -> RUN when no request is seen.
- flush_req overrides both.

Watchdog:
- The run counter increments on each edge where stall!=0, saturating at STALL_LIMIT.
- It clears on an edge where stall==0, including every FLUSH cycle.
- When it reaches STALL_LIMIT, stall_timeout sets to 1 and stays set until reset.

Boundaries:
- Requests deasserting mid-stall release stall in the same cycle. There is no minimum hold time.
- Reset asserted mid-FLUSH or mid-STALL clears all outputs immediately.

Optional Feature:
Macro PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each edge where stall!=0.
  - flush_cnt increments on each edge where state is FLUSH.
  - Both wrap modulo 2^CNT_W.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are built. Ports remain present.

Test Plan:
1. Reset release with no requests, 10 cycles -> stall=6'b000000, flush=0, new_pc=0, stall_timeout=0 throughout.
2. stallreq_id=1 for 3 cycles, then stallreq_ex=1 together with stallreq_id for 2 cycles, then both 0:
   - stall = 000111 ×3, then 001111 ×2, then 000000 in the same cycle the requests drop.
   - With the macro defined: stall_cnt=5.
3. flush_req pulse with flush_pc=32'hBFC00380 while stallreq_ex=1:
   - This cycle: stall=001111.
   - Next cycle: flush=1, new_pc=32'hBFC00380, stall=000000.
   - Following cycle: flush=0.
   - With the macro defined: flush_cnt=1.
4. flush_req on two consecutive cycles with flush_pc=32'h100 then 32'h200 -> flush=1 for 2 cycles, new_pc=32'h100 then 32'h200.
5. STALL_LIMIT=8, stallreq_ex held for 10 cycles:
   - stall_timeout rises after the 8th stalled edge and stays 1 after the request drops.
   - Only rst=0 clears it.
6. rst=0 asserted asynchronously during a FLUSH cycle -> flush, stall and new_pc go to 0 immediately, without waiting for a clock edge.
